// File: rtl/mii_pkg.sv
// Shared MII definitions: control codes, preamble bytes and the generator state encoding.
// Used by both the frame generator and the downstream checker.
package mii_pkg;

    localparam logic [7:0] MII_IDLE     = 8'h07;
    localparam logic [7:0] MII_START    = 8'hFB;
    localparam logic [7:0] MII_TERM     = 8'hFD;
    localparam logic [7:0] MII_ERROR    = 8'hFE;
    localparam logic [7:0] MII_PREAMBLE = 8'h55;
    localparam logic [7:0] MII_SFD      = 8'hD5;

    typedef enum logic [2:0] {
        GEN_IDLE,
        GEN_PREAMBLE,
        GEN_DATA,
        GEN_TERM,
        GEN_IPG
    } gen_state_t;

endpackage

// File: rtl/mii_last_word_enc.sv
// Builds the closing word of a frame: data below lane r, TERM at lane r, IDLE above it.
// With r=0 it produces the stand-alone TERM word.
module mii_last_word_enc
    import mii_pkg::*;
#(
    parameter int         LANES     = 8,
    parameter logic [7:0] TERM_CODE = MII_TERM,
    parameter logic [7:0] IDLE_CODE = MII_IDLE
) (
    input  logic [LANES*8-1:0]         i_data,
    input  logic [$clog2(LANES)-1:0]   i_lane,
    output logic [LANES*8-1:0]         o_data,
    output logic [LANES-1:0]           o_ctrl
);

    localparam int LANE_W = $clog2(LANES);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic below;
        logic at;

        assign below             = LANE_W'(k) < i_lane;
        assign at                = LANE_W'(k) == i_lane;
        assign o_data[8*k +: 8]  = below ? i_data[8*k +: 8] : (at ? TERM_CODE : IDLE_CODE);
        assign o_ctrl[k]         = ~below;
    end

endmodule

// File: rtl/mii_frame_generator.sv
// 64-bit MII TX framer: START/preamble, payload, TERM, then IDLE fill until the
// programmed inter-packet gap is met. Every output word is registered.
module mii_frame_generator
    import mii_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         CTRL_WIDTH = 8,
    parameter int         LEN_WIDTH  = 11,
    parameter logic [7:0] IDLE_CODE  = MII_IDLE,
    parameter logic [7:0] START_CODE = MII_START,
    parameter logic [7:0] TERM_CODE  = MII_TERM,
    parameter logic [7:0] ERROR_CODE = MII_ERROR
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_frame_len,
    input  logic [7:0]            i_ipg_bytes,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_underrun
);

    localparam int                    LANE_W        = $clog2(CTRL_WIDTH);
    localparam logic [LEN_WIDTH-1:0]  WORD_BYTES    = LEN_WIDTH'(CTRL_WIDTH);
    localparam logic [8:0]            LAST_LANE     = 9'(CTRL_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] IDLE_WORD     = {CTRL_WIDTH{IDLE_CODE}};
    localparam logic [DATA_WIDTH-1:0] ERROR_WORD    = {CTRL_WIDTH{ERROR_CODE}};
    localparam logic [DATA_WIDTH-1:0] PREAMBLE_WORD =
        {MII_SFD, {(CTRL_WIDTH-2){MII_PREAMBLE}}, START_CODE};

    gen_state_t             state_q;
    logic [LEN_WIDTH-1:0]   rem_q;
    logic [7:0]             ipg_lat_q;
    logic [8:0]             ipg_cnt_q;
    logic [DATA_WIDTH-1:0]  tx_data_q;
    logic [CTRL_WIDTH-1:0]  tx_ctrl_q;
    logic                   frame_done_q;
    logic                   underrun_q;

    logic [LANE_W-1:0]      enc_lane;
    logic [DATA_WIDTH-1:0]  enc_data;
    logic [CTRL_WIDTH-1:0]  enc_ctrl;
    logic [8:0]             tail_cnt_d;
    logic [8:0]             ipg_cnt_d;

    assign enc_lane   = (state_q == GEN_TERM) ? '0 : rem_q[LANE_W-1:0];
    assign tail_cnt_d = LAST_LANE - 9'(enc_lane);
    assign ipg_cnt_d  = ipg_cnt_q + 9'd8;

    mii_last_word_enc #(
        .LANES     (CTRL_WIDTH),
        .TERM_CODE (TERM_CODE),
        .IDLE_CODE (IDLE_CODE)
    ) u_last_word (
        .i_data (i_data),
        .i_lane (enc_lane),
        .o_data (enc_data),
        .o_ctrl (enc_ctrl)
    );

    // Done is a look-ahead: it is registered with the word that first satisfies the gap.
    function automatic logic gap_met(input logic [8:0] cnt, input logic [7:0] lat);
        return cnt >= {1'b0, lat};
    endfunction

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q      <= GEN_IDLE;
            rem_q        <= '0;
            ipg_lat_q    <= '0;
            ipg_cnt_q    <= '0;
            tx_data_q    <= IDLE_WORD;
            tx_ctrl_q    <= '1;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            case (state_q)
                GEN_IDLE: begin
                    tx_data_q <= IDLE_WORD;
                    tx_ctrl_q <= '1;
                    if (i_start) begin
                        rem_q     <= i_frame_len;
                        ipg_lat_q <= i_ipg_bytes;
                        ipg_cnt_q <= '0;
                        state_q   <= GEN_PREAMBLE;
                    end
                end
                GEN_PREAMBLE: begin
                    tx_data_q <= PREAMBLE_WORD;
                    tx_ctrl_q <= CTRL_WIDTH'(1);
                    state_q   <= (rem_q == '0) ? GEN_TERM : GEN_DATA;
                end
                GEN_DATA: begin
                    if (!i_data_valid) begin
                        tx_data_q    <= ERROR_WORD;
                        tx_ctrl_q    <= '1;
                        underrun_q   <= 1'b1;
                        ipg_cnt_q    <= '0;
                        frame_done_q <= gap_met(9'd0, ipg_lat_q);
                        state_q      <= GEN_IPG;
                    end else if (rem_q > WORD_BYTES) begin
                        tx_data_q <= i_data;
                        tx_ctrl_q <= '0;
                        rem_q     <= rem_q - WORD_BYTES;
                    end else if (rem_q == WORD_BYTES) begin
                        tx_data_q <= i_data;
                        tx_ctrl_q <= '0;
                        state_q   <= GEN_TERM;
                    end else begin
                        tx_data_q    <= enc_data;
                        tx_ctrl_q    <= enc_ctrl;
                        ipg_cnt_q    <= tail_cnt_d;
                        frame_done_q <= gap_met(tail_cnt_d, ipg_lat_q);
                        state_q      <= GEN_IPG;
                    end
                end
                GEN_TERM: begin
                    tx_data_q    <= enc_data;
                    tx_ctrl_q    <= enc_ctrl;
                    ipg_cnt_q    <= tail_cnt_d;
                    frame_done_q <= gap_met(tail_cnt_d, ipg_lat_q);
                    state_q      <= GEN_IPG;
                end
                GEN_IPG: begin
                    tx_data_q <= IDLE_WORD;
                    tx_ctrl_q <= '1;
                    if (gap_met(ipg_cnt_q, ipg_lat_q)) begin
                        state_q <= GEN_IDLE;
                    end else begin
                        ipg_cnt_q    <= ipg_cnt_d;
                        frame_done_q <= gap_met(ipg_cnt_d, ipg_lat_q);
                    end
                end
                default: state_q <= GEN_IDLE;
            endcase
        end
    end

    assign o_data_ready = (state_q == GEN_DATA);
    assign o_busy       = (state_q != GEN_IDLE);
    assign o_tx_data    = tx_data_q;
    assign o_tx_ctrl    = tx_ctrl_q;
    assign o_frame_done = frame_done_q;
    assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_mii_frame_generator.sv
// Directed bench for mii_frame_generator: each step drives inputs, advances one clock,
// and compares the registered outputs against hand-computed words.
module tb_mii_frame_generator;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [10:0] i_frame_len;
    logic [7:0]  i_ipg_bytes;
    logic [63:0] i_data;
    logic        i_data_valid;
    logic        o_data_ready;
    logic [63:0] o_tx_data;
    logic [7:0]  o_tx_ctrl;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_underrun;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W = 64'h07070707070707FD;
    localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] PART_W = 64'h0707FDC7B7A79787;

    mii_frame_generator dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_frame_len  (i_frame_len),
        .i_ipg_bytes  (i_ipg_bytes),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .o_tx_data    (o_tx_data),
        .o_tx_ctrl    (o_tx_ctrl),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_underrun   (o_underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dw(input int w);
        logic [7:0] b;
        b = 8'(w);
        return {8{b}} ^ 64'hF0E0D0C0B0A09080;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [63:0] d, input logic [7:0] c);
        chk({tag, "/data"}, o_tx_data, d);
        chk({tag, "/ctrl"}, {56'b0, o_tx_ctrl}, {56'b0, c});
    endtask

    task automatic chk_flags(input string tag, input logic busy, input logic done, input logic und);
        chk({tag, "/busy"}, {63'b0, o_busy}, {63'b0, busy});
        chk({tag, "/done"}, {63'b0, o_frame_done}, {63'b0, done});
        chk({tag, "/underrun"}, {63'b0, o_underrun}, {63'b0, und});
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_frame_len = '0; i_ipg_bytes = '0;
        i_data = '0; i_data_valid = 1'b0;
        tick(); tick();
        chk_word("reset", IDLE_W, 8'hFF);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        chk("reset/ready", {63'b0, o_data_ready}, 64'd0);
        i_rst = 1'b0;
        tick();
        chk_word("idle", IDLE_W, 8'hFF);

        // 1: 64 bytes, ipg 12 -> 8 words, TERM word, one IDLE word carrying done
        i_frame_len = 11'd64; i_ipg_bytes = 8'd12; i_start = 1'b1; i_data_valid = 1'b1;
        tick();
        chk_flags("t1 accept", 1'b1, 1'b0, 1'b0);
        chk_word("t1 accept", IDLE_W, 8'hFF);
        i_start = 1'b0;
        tick();
        chk_word("t1 pre", PRE_W, 8'h01);
        chk("t1 ready", {63'b0, o_data_ready}, 64'd1);
        for (int w = 0; w < 8; w++) begin
            i_data = dw(w);
            tick();
            chk_word($sformatf("t1 w%0d", w), dw(w), 8'h00);
        end
        chk("t1 ready after last", {63'b0, o_data_ready}, 64'd0);
        tick();
        chk_word("t1 term", TERM_W, 8'hFF);
        chk_flags("t1 term", 1'b1, 1'b0, 1'b0);
        tick();
        chk_word("t1 ipg", IDLE_W, 8'hFF);
        chk_flags("t1 ipg", 1'b1, 1'b1, 1'b0);
        tick();
        chk_flags("t1 end", 1'b0, 1'b0, 1'b0);

        // 2: 61 bytes -> partial last word, FD at lane 5; inputs changed after accept
        i_frame_len = 11'd61; i_ipg_bytes = 8'd12; i_start = 1'b1;
        tick();
        i_start = 1'b0; i_frame_len = 11'd5; i_ipg_bytes = 8'd0;
        tick();
        chk_word("t2 pre", PRE_W, 8'h01);
        for (int w = 0; w < 7; w++) begin
            i_data = dw(w);
            tick();
            chk_word($sformatf("t2 w%0d", w), dw(w), 8'h00);
        end
        i_data = dw(7);
        tick();
        chk_word("t2 last", PART_W, 8'hE0);
        chk_flags("t2 last", 1'b1, 1'b0, 1'b0);
        tick();
        chk_word("t2 ipg0", IDLE_W, 8'hFF);
        chk_flags("t2 ipg0", 1'b1, 1'b0, 1'b0);
        tick();
        chk_word("t2 ipg1", IDLE_W, 8'hFF);
        chk_flags("t2 ipg1", 1'b1, 1'b1, 1'b0);
        tick();
        chk_flags("t2 end", 1'b0, 1'b0, 1'b0);

        // 3: zero-length, ipg 0 -> preamble, TERM with done; busy for three cycles
        i_frame_len = 11'd0; i_ipg_bytes = 8'd0; i_start = 1'b1;
        tick();
        chk_flags("t3 accept", 1'b1, 1'b0, 1'b0);
        i_start = 1'b0;
        tick();
        chk_word("t3 pre", PRE_W, 8'h01);
        chk("t3 ready", {63'b0, o_data_ready}, 64'd0);
        tick();
        chk_word("t3 term", TERM_W, 8'hFF);
        chk_flags("t3 term", 1'b1, 1'b1, 1'b0);
        tick();
        chk_word("t3 end", IDLE_W, 8'hFF);
        chk_flags("t3 end", 1'b0, 1'b0, 1'b0);

        // 4: valid dropped at word 3 -> error word and underrun, no TERM
        i_frame_len = 11'd64; i_ipg_bytes = 8'd12; i_start = 1'b1; i_data_valid = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        for (int w = 0; w < 3; w++) begin
            i_data = dw(w + 8);
            tick();
            chk_word($sformatf("t4 w%0d", w), dw(w + 8), 8'h00);
        end
        i_data_valid = 1'b0;
        tick();
        chk_word("t4 err", ERR_W, 8'hFF);
        chk_flags("t4 err", 1'b1, 1'b0, 1'b1);
        i_data_valid = 1'b1;
        tick();
        chk_word("t4 ipg0", IDLE_W, 8'hFF);
        chk_flags("t4 ipg0", 1'b1, 1'b0, 1'b0);
        tick();
        chk_word("t4 ipg1", IDLE_W, 8'hFF);
        chk_flags("t4 ipg1", 1'b1, 1'b1, 1'b0);
        tick();
        chk_flags("t4 end", 1'b0, 1'b0, 1'b0);

        // 5: start held high -> one IDLE-state cycle between frames, no restart mid-frame
        i_frame_len = 11'd8; i_ipg_bytes = 8'd0; i_start = 1'b1; i_data = dw(3);
        tick();
        tick();
        chk_word("t5 pre", PRE_W, 8'h01);
        tick();
        chk_word("t5 data", dw(3), 8'h00);
        tick();
        chk_word("t5 term", TERM_W, 8'hFF);
        chk_flags("t5 term", 1'b1, 1'b1, 1'b0);
        tick();
        chk_word("t5 gap", IDLE_W, 8'hFF);
        chk_flags("t5 gap", 1'b0, 1'b0, 1'b0);
        tick();
        chk_word("t5 accept2", IDLE_W, 8'hFF);
        chk_flags("t5 accept2", 1'b1, 1'b0, 1'b0);
        i_start = 1'b0;
        tick();
        chk_word("t5 pre2", PRE_W, 8'h01);
        tick();
        chk_word("t5 data2", dw(3), 8'h00);
        tick();
        chk_word("t5 term2", TERM_W, 8'hFF);
        chk_flags("t5 term2", 1'b1, 1'b1, 1'b0);
        tick();
        chk_flags("t5 end", 1'b0, 1'b0, 1'b0);

        // 6: reset in the middle of DATA, then a clean short frame
        i_frame_len = 11'd64; i_ipg_bytes = 8'd12; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_data = dw(0);
        tick();
        chk_word("t6 w0", dw(0), 8'h00);
        i_rst = 1'b1;
        tick();
        chk_word("t6 rst", IDLE_W, 8'hFF);
        chk_flags("t6 rst", 1'b0, 1'b0, 1'b0);
        chk("t6 rst/ready", {63'b0, o_data_ready}, 64'd0);
        i_rst = 1'b0;
        i_frame_len = 11'd8; i_ipg_bytes = 8'd4; i_start = 1'b1; i_data = dw(5);
        tick();
        chk_flags("t6 accept", 1'b1, 1'b0, 1'b0);
        i_start = 1'b0;
        tick();
        chk_word("t6 pre", PRE_W, 8'h01);
        tick();
        chk_word("t6 data", dw(5), 8'h00);
        tick();
        chk_word("t6 term", TERM_W, 8'hFF);
        chk_flags("t6 term", 1'b1, 1'b1, 1'b0);
        tick();
        chk_word("t6 end", IDLE_W, 8'hFF);
        chk_flags("t6 end", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
